bus_initiator_fsm: RTL and testbench
====================================

Name: bus_initiator_fsm

Overview:
- Initiator (host) end of the 32-bit handshake bus: turns one-word command requests into a full handshake1_1/handshake1_2 transaction and returns the read word or a timeout status.
- Targets the bus responder FSM.
- Used as the on-chip master for FPGA-to-FPGA links and as the synthesizable bus-functional master in system benches.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles waiting on either handshake1_2 edge before abort; must be >= 4.
- SYNC_STAGES, 2: flop depth of the handshake1_2 synchroniser; must be >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_rw  in  1  1 = read (responder sends data), 0 = write
- cmd_word  in  32  word placed on bus_out (address/data)
- rsp_valid  out  1  one-cycle pulse: transaction finished
- rsp_word  out  32  captured bus_in word (reads); 0 for writes
- rsp_timeout  out  1  qualifies rsp_valid; 1 = transaction aborted
- RW  out  1  bus direction to responder, registered copy of cmd_rw
- handshake1_1  out  1  request strobe to responder
- handshake1_2  in  1  acknowledge from responder, asynchronous
- bus_out  out  32  word to responder
- bus_in  in  32  word from responder; stable from handshake1_2 rise until handshake1_1 fall
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_word=0, rsp_timeout=0, RW=0, handshake1_1=0, bus_out=0, busy=0, timeout counter=0, synchroniser flops=0.
- Outputs are Moore: every output is registered or decoded from the state register only. No combinational path from any input to any output.
- ack_s is handshake1_2 after SYNC_STAGES flops. All FSM decisions use ack_s.
- IDLE:
  - cmd_ready=1.
  - On accept, latch cmd_rw into RW and cmd_word into bus_out, then go to SETUP.
- SETUP: one cycle with handshake1_1=0, giving bus_out/RW setup time; go to REQ.
- REQ:
  - handshake1_1=1; counter increments each cycle.
  - ack_s=1: go to CAPTURE.
  - counter reaches TIMEOUT_CYCLES-1: go to ABORT.
- CAPTURE:
  - handshake1_1=1.
  - rsp_word <= bus_in if RW=1, else 0.
  - Counter cleared; go to RELEASE.
- RELEASE:
  - handshake1_1=0; counter increments.
  - ack_s=0: go to DONE.
  - Timeout: go to ABORT.
- DONE: rsp_valid=1, rsp_timeout=0; go to IDLE.
- ABORT:
  - handshake1_1=0, rsp_valid=1, rsp_timeout=1, rsp_word=0; go to IDLE.
  - A stuck-high ack is not waited on.
- cmd_ready=0 in every state except IDLE. cmd_valid outside IDLE is ignored, not queued.
- bus_out and RW hold their latched value from accept until the next accept. They are not cleared on completion.
- Best-case latency, accept to rsp_valid: 1 (SETUP) + 1 + SYNC_STAGES (REQ) + 1 (CAPTURE) + 1 + SYNC_STAGES (RELEASE) + 1 (DONE).
- Counter width is $clog2(TIMEOUT_CYCLES). It saturates; it never wraps.
- If ack_s is already 1 on entry to REQ (stale ack), it is treated as a valid ack. The responder protocol forbids this case, and a bench assertion flags it.
- Reset mid-transaction: handshake1_1 drops asynchronously and all state returns to reset values; no rsp_valid is produced.
- The state enum uses unique case with an explicit default to IDLE.

Optional Feature:
- BUS_INITIATOR_STATS_EN.
- Defined:
  - Adds outputs stat_xfer_count (16b, counts DONE) and stat_timeout_count (16b, counts ABORT).
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package bus_pkg:
  - BUS_WIDTH=32.
  - Initiator state enum {IDLE, SETUP, REQ, CAPTURE, RELEASE, DONE, ABORT}, 3 bits.
  - Typedef bus_word_t.
  - Shared with the responder FSM.
- Sub-module bit_synchroniser (parameter STAGES, async active-low reset) for handshake1_2.

Test Plan:
- Write: cmd_rw=0, cmd_word=32'hDEAD_BEEF; responder acks 3 cycles after handshake1_1 rises, drops ack 2 cycles after handshake1_1 falls -> bus_out=DEADBEEF and RW=0 throughout; one rsp_valid, rsp_timeout=0, rsp_word=0.
- Read: cmd_rw=1, cmd_word=32'h0000_0010; responder drives bus_in=32'h1234_5678 with ack -> rsp_word=12345678; zero-delay responder gives accept-to-rsp_valid = 9 cycles at SYNC_STAGES=2.
- Timeout: TIMEOUT_CYCLES=8, no ack ever -> handshake1_1 high exactly 8 cycles; rsp_valid with rsp_timeout=1; back to IDLE with cmd_ready=1.
- Stuck ack: ack rises and never falls -> ABORT after TIMEOUT_CYCLES in RELEASE; rsp_timeout=1; next command accepted.
- Reset: assert reset while in REQ -> handshake1_1=0 immediately (before next clk edge); all outputs at reset values; no rsp_valid.
- Back-to-back: cmd_valid held high for 2 commands -> second accepted only on the cycle after rsp_valid; cmd_valid during busy produces no extra transaction.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the 32-bit handshake bus.
// Used by both the initiator and the responder FSMs.
// The initiator state codes are plain 3-bit constants so that
// older tools and netlist viewers see stable numeric encodings.
package bus_pkg;

   // Width of the data/address word carried on the bus.
   localparam int BUS_WIDTH = 32;

   // Width of the optional statistics counters.
   localparam int STAT_W = 16;

   typedef logic [BUS_WIDTH-1:0] bus_word_t;
   typedef logic [2:0]           init_state_t;

   // Initiator FSM state encodings.
   localparam init_state_t IDLE    = 3'd0;
   localparam init_state_t SETUP   = 3'd1;
   localparam init_state_t REQ     = 3'd2;
   localparam init_state_t CAPTURE = 3'd3;
   localparam init_state_t RELEASE = 3'd4;
   localparam init_state_t DONE    = 3'd5;
   localparam init_state_t ABORT   = 3'd6;

   // The request strobe is high while waiting for the acknowledge and
   // during the capture cycle. Keeping this in one place means the
   // initiator and any bus monitors agree on when it should be high.
   function automatic logic strobe_high(input init_state_t s);
      return (s == REQ) || (s == CAPTURE);
   endfunction

endpackage

// File: rtl/bit_synchroniser.sv
// Multi-flop synchroniser for a single asynchronous control bit.
// The first flop may go metastable. The rest of the chain gives it
// time to resolve before q_o is used by the clocked logic.
module bit_synchroniser #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw input through the chain. Reset clears every stage so
   // that no stale acknowledge is seen after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/bus_initiator_fsm.sv
// Initiator (host) end of the 32-bit handshake bus.
// It accepts one command word at a time and runs the full
// handshake1_1 / handshake1_2 request-acknowledge cycle against the responder.
// It then returns either the captured read word or a timeout status.
// Every output comes from a register or is decoded from the state register,
// so there is no combinational path from any input to any output.
// Optional build macro: BUS_INITIATOR_STATS_EN adds saturating 16-bit
// completed-transfer and timeout counters.
module bus_initiator_fsm
   import bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int SYNC_STAGES    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [31:0]       cmd_word,
   output logic              rsp_valid,
   output logic [31:0]       rsp_word,
   output logic              rsp_timeout,
   output logic              RW,
   output logic              handshake1_1,
   input  logic              handshake1_2,
   output logic [31:0]       bus_out,
   input  logic [31:0]       bus_in,
   output logic              busy
`ifdef BUS_INITIATOR_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_xfer_count,
   output logic [STAT_W-1:0] stat_timeout_count
`endif
);

   // The counter holds values 0..TIMEOUT_CYCLES-1. It saturates rather
   // than wrapping, so a long stall can never look like a fresh count.
   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   init_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cntInc;
   logic              rw_q, rw_d;
   bus_word_t         busOut_q, busOut_d;
   bus_word_t         rspWord_q, rspWord_d;
   logic              ackS;
   logic              cntExpired;

   // The acknowledge arrives from another clock domain or another chip.
   // Only its synchronised copy is allowed to steer the FSM.
   bit_synchroniser #(
      .STAGES(SYNC_STAGES)
   ) u_ackSync (
      .clk_i (clk),
      .rst_ni(reset),
      .d_i   (handshake1_2),
      .q_o   (ackS)
   );

   assign cntInc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   assign cntExpired = (cnt_q >= CNT_LAST);

   // Next-state and datapath logic for the handshake sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rw_d      = rw_q;
      busOut_d  = busOut_q;
      rspWord_d = rspWord_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (cmd_valid) begin
               rw_d     = cmd_rw;
               busOut_d = cmd_word;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = REQ;
         end
         REQ: begin
            cnt_d = cntInc;
            if (ackS) begin
               state_d = CAPTURE;
            end else if (cntExpired) begin
               rspWord_d = '0;
               state_d   = ABORT;
            end
         end
         CAPTURE: begin
            cnt_d     = '0;
            rspWord_d = rw_q ? bus_in : '0;
            state_d   = RELEASE;
         end
         RELEASE: begin
            cnt_d = cntInc;
            if (!ackS) begin
               state_d = DONE;
            end else if (cntExpired) begin
               rspWord_d = '0;
               state_d   = ABORT;
            end
         end
         DONE: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         ABORT: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and latched bus registers.
   // Reset is asynchronous, so the strobe drops as soon as reset asserts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rw_q      <= 1'b0;
         busOut_q  <= '0;
         rspWord_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rw_q      <= rw_d;
         busOut_q  <= busOut_d;
         rspWord_q <= rspWord_d;
      end
   end

   assign cmd_ready    = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign handshake1_1 = strobe_high(state_q);
   assign rsp_valid    = (state_q == DONE) || (state_q == ABORT);
   assign rsp_timeout  = (state_q == ABORT);
   assign RW           = rw_q;
   assign bus_out      = busOut_q;
   assign rsp_word     = rspWord_q;

`ifdef BUS_INITIATOR_STATS_EN
   logic [STAT_W-1:0] xferCnt_q;
   logic [STAT_W-1:0] toCnt_q;

   // Count completed and aborted transactions. Both counters stick at
   // all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xferCnt_q <= '0;
         toCnt_q   <= '0;
      end else begin
         if ((state_q == DONE) && (xferCnt_q != '1)) begin
            xferCnt_q <= xferCnt_q + STAT_W'(1);
         end
         if ((state_q == ABORT) && (toCnt_q != '1)) begin
            toCnt_q <= toCnt_q + STAT_W'(1);
         end
      end
   end

   assign stat_xfer_count    = xferCnt_q;
   assign stat_timeout_count = toCnt_q;
`endif

endmodule

// File: tb/tb_bus_initiator_fsm.sv
// Directed self-checking bench for bus_initiator_fsm.
// A small behavioural responder answers the handshake in one of four modes:
// silent, delayed, stuck-high or zero-delay.
module tb_bus_initiator_fsm;

   localparam int TO_CYC = 8;
   localparam int SYNC   = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_rw;
   logic [31:0] cmd_word;
   logic        rsp_valid;
   logic [31:0] rsp_word;
   logic        rsp_timeout;
   logic        RW;
   logic        handshake1_1;
   logic        handshake1_2;
   logic [31:0] bus_out;
   logic [31:0] bus_in;
   logic        busy;
`ifdef BUS_INITIATOR_STATS_EN
   logic [15:0] stat_xfer_count;
   logic [15:0] stat_timeout_count;
`endif

   int checks = 0;
   int errors = 0;

   // Responder model controls: 0 silent, 1 delayed, 2 stuck, 3 zero-delay
   int          respMode  = 0;
   int          ackDelay  = 3;
   int          dropDelay = 2;
   logic [31:0] respWord  = '0;
   logic        ackReg    = 1'b0;
   int          highCnt   = 0;
   int          lowCnt    = 0;

   // Monitors
   int   acceptCount = 0;
   int   rspCount    = 0;
   int   ackLowRun   = 0;
   logic hsPrev      = 1'b0;

   bus_initiator_fsm #(
      .TIMEOUT_CYCLES(TO_CYC),
      .SYNC_STAGES   (SYNC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_rw      (cmd_rw),
      .cmd_word    (cmd_word),
      .rsp_valid   (rsp_valid),
      .rsp_word    (rsp_word),
      .rsp_timeout (rsp_timeout),
      .RW          (RW),
      .handshake1_1(handshake1_1),
      .handshake1_2(handshake1_2),
      .bus_out     (bus_out),
      .bus_in      (bus_in),
      .busy        (busy)
`ifdef BUS_INITIATOR_STATS_EN
      ,
      .stat_xfer_count   (stat_xfer_count),
      .stat_timeout_count(stat_timeout_count)
`endif
   );

   always #5 clk = ~clk;

   assign handshake1_2 = (respMode == 3) ? handshake1_1 : ackReg;
   assign bus_in       = respWord;

   // Responder model, driven on the falling edge so that its outputs are
   // stable around the rising edge.
   always @(negedge clk) begin
      case (respMode)
         1: begin
            if (handshake1_1) begin
               lowCnt = 0;
               if (!ackReg) begin
                  highCnt = highCnt + 1;
                  if (highCnt >= ackDelay) ackReg = 1'b1;
               end
            end else begin
               highCnt = 0;
               if (ackReg) begin
                  lowCnt = lowCnt + 1;
                  if (lowCnt >= dropDelay) ackReg = 1'b0;
               end
            end
         end
         2: begin
            if (handshake1_1) ackReg = 1'b1;
         end
         default: begin
            ackReg  = 1'b0;
            highCnt = 0;
            lowCnt  = 0;
         end
      endcase
   end

   // Count accepted commands and response pulses, and track how long the
   // acknowledge has been low.
   always @(posedge clk) begin
      if (cmd_valid && cmd_ready) acceptCount = acceptCount + 1;
      if (rsp_valid) rspCount = rspCount + 1;
      ackLowRun = handshake1_2 ? 0 : ((ackLowRun < 1000) ? ackLowRun + 1 : ackLowRun);
   end

   // Flag a stale acknowledge: when the request strobe rises, the
   // acknowledge must have been low for at least the synchroniser depth.
   always @(negedge clk) begin
      if (handshake1_1 && !hsPrev) begin
         assert (ackLowRun >= SYNC) else begin
            errors = errors + 1;
            $error("[TB] FAIL stale_ack observed=%0d expected>=%0d", ackLowRun, SYNC);
         end
      end
      hsPrev = handshake1_1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks = checks + 1;
      assert (observed === expected) else begin
         errors = errors + 1;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Issue one command from IDLE and follow it until rsp_valid or budget.
   task automatic applyStimulus(input logic rw, input logic [31:0] word, input int budget,
                                output int lat, output logic gotRsp, output logic gotTo,
                                output logic [31:0] gotWord, output logic busOk,
                                output int hsHigh);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_rw    = rw;
      cmd_word  = word;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_rw    = 1'b0;
      cmd_word  = '0;
      lat       = 1;
      gotRsp    = 1'b0;
      gotTo     = 1'b0;
      gotWord   = '0;
      busOk     = 1'b1;
      hsHigh    = 0;
      for (int i = 0; i < budget; i++) begin
         if (bus_out !== word || RW !== rw) busOk = 1'b0;
         if (handshake1_1) hsHigh = hsHigh + 1;
         if (rsp_valid) begin
            gotRsp  = 1'b1;
            gotTo   = rsp_timeout;
            gotWord = rsp_word;
            break;
         end
         @(posedge clk);
         #1;
         lat = lat + 1;
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          lat;
      int          hsHigh;
      int          base;
      logic        gotRsp;
      logic        gotTo;
      logic        busOk;
      logic [31:0] gotWord;
      logic        sawValid;

      reset     = 1'b0;
      cmd_valid = 1'b0;
      cmd_rw    = 1'b0;
      cmd_word  = '0;

      // Reset values
      #12;
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_hs1", 32'(handshake1_1), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
      checkOutput("rst_rsp_word", rsp_word, 32'd0);
      checkOutput("rst_bus_out", bus_out, 32'd0);
      checkOutput("rst_rw", 32'(RW), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Read with a zero-delay responder
      respMode = 3;
      respWord = 32'h1234_5678;
      applyStimulus(1'b1, 32'h0000_0010, 40, lat, gotRsp, gotTo, gotWord, busOk, hsHigh);
      checkOutput("rd_valid", 32'(gotRsp), 32'd1);
      checkOutput("rd_latency", 32'(lat), 32'd9);
      checkOutput("rd_timeout", 32'(gotTo), 32'd0);
      checkOutput("rd_word", gotWord, 32'h1234_5678);
      checkOutput("rd_bus_stable", 32'(busOk), 32'd1);
      checkOutput("rd_hs1_cycles", 32'(hsHigh), 32'd4);
      @(posedge clk);
      #1;
      checkOutput("rd_pulse_end", 32'(rsp_valid), 32'd0);
      checkOutput("rd_ready_after", 32'(cmd_ready), 32'd1);
      checkOutput("rd_bus_held", bus_out, 32'h0000_0010);
      checkOutput("rd_rw_held", 32'(RW), 32'd1);

      // Write with a delayed responder
      respMode  = 1;
      ackDelay  = 3;
      dropDelay = 2;
      respWord  = 32'hAAAA_5555;
      base      = rspCount;
      applyStimulus(1'b0, 32'hDEAD_BEEF, 40, lat, gotRsp, gotTo, gotWord, busOk, hsHigh);
      checkOutput("wr_valid", 32'(gotRsp), 32'd1);
      checkOutput("wr_latency", 32'(lat), 32'd12);
      checkOutput("wr_timeout", 32'(gotTo), 32'd0);
      checkOutput("wr_word", gotWord, 32'd0);
      checkOutput("wr_bus_stable", 32'(busOk), 32'd1);
      checkOutput("wr_hs1_cycles", 32'(hsHigh), 32'd6);
      @(posedge clk);
      #1;
      checkOutput("wr_one_pulse", 32'(rspCount - base), 32'd1);

      // Timeout with no acknowledge
      respMode = 0;
      applyStimulus(1'b1, 32'h0000_0020, 40, lat, gotRsp, gotTo, gotWord, busOk, hsHigh);
      checkOutput("to_valid", 32'(gotRsp), 32'd1);
      checkOutput("to_timeout", 32'(gotTo), 32'd1);
      checkOutput("to_word", gotWord, 32'd0);
      checkOutput("to_hs1_cycles", 32'(hsHigh), 32'd8);
      checkOutput("to_latency", 32'(lat), 32'd10);
      @(posedge clk);
      #1;
      checkOutput("to_ready_after", 32'(cmd_ready), 32'd1);
      checkOutput("to_busy_after", 32'(busy), 32'd0);

      // Stuck-high acknowledge aborts from RELEASE
      respMode = 2;
      respWord = 32'hCAFE_F00D;
      applyStimulus(1'b1, 32'h0000_0030, 40, lat, gotRsp, gotTo, gotWord, busOk, hsHigh);
      checkOutput("stk_valid", 32'(gotRsp), 32'd1);
      checkOutput("stk_latency", 32'(lat), 32'd14);
      checkOutput("stk_timeout", 32'(gotTo), 32'd1);
      checkOutput("stk_word", gotWord, 32'd0);
      checkOutput("stk_hs1_cycles", 32'(hsHigh), 32'd4);
      respMode = 0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("stk_ready_after", 32'(cmd_ready), 32'd1);
      respMode = 3;
      respWord = 32'h0BAD_C0DE;
      applyStimulus(1'b1, 32'h0000_0040, 40, lat, gotRsp, gotTo, gotWord, busOk, hsHigh);
      checkOutput("stk_next_valid", 32'(gotRsp), 32'd1);
      checkOutput("stk_next_timeout", 32'(gotTo), 32'd0);
      checkOutput("stk_next_word", gotWord, 32'h0BAD_C0DE);
      checkOutput("stk_next_latency", 32'(lat), 32'd9);
      repeat (2) @(posedge clk);

      // Reset asserted while in REQ
      respMode = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_rw    = 1'b1;
      cmd_word  = 32'h55AA_55AA;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("mid_hs1_before", 32'(handshake1_1), 32'd1);
      base = rspCount;
      #2;
      reset = 1'b0;
      #1;
      checkOutput("mid_hs1_async", 32'(handshake1_1), 32'd0);
      checkOutput("mid_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("mid_busy", 32'(busy), 32'd0);
      checkOutput("mid_bus_out", bus_out, 32'd0);
      checkOutput("mid_rw", 32'(RW), 32'd0);
      checkOutput("mid_rsp_word", rsp_word, 32'd0);
      checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("mid_no_rsp", 32'(rspCount - base), 32'd0);
      checkOutput("mid_idle_after", 32'(busy), 32'd0);

      // Back-to-back with cmd_valid held high
      respMode = 3;
      respWord = 32'h1111_2222;
      base     = acceptCount;
      sawValid = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_rw    = 1'b1;
      cmd_word  = 32'h0000_0100;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            sawValid = 1'b1;
            break;
         end
      end
      checkOutput("b2b_first_valid", 32'(sawValid), 32'd1);
      checkOutput("b2b_ready_at_rsp", 32'(cmd_ready), 32'd0);
      checkOutput("b2b_one_accept", 32'(acceptCount - base), 32'd1);
      cmd_word = 32'h0000_0200;
      @(posedge clk);
      #1;
      checkOutput("b2b_ready_idle", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      checkOutput("b2b_two_accepts", 32'(acceptCount - base), 32'd2);
      checkOutput("b2b_busy", 32'(busy), 32'd1);
      checkOutput("b2b_bus_out", bus_out, 32'h0000_0200);
      sawValid = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            sawValid = 1'b1;
            break;
         end
      end
      checkOutput("b2b_second_valid", 32'(sawValid), 32'd1);
      checkOutput("b2b_second_word", rsp_word, 32'h1111_2222);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("b2b_no_extra", 32'(acceptCount - base), 32'd2);
      checkOutput("b2b_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
